// File: rtl/fpalu_result_pack.sv
// Result pack stage of the FP ALU: normalizes the unified-format result, rounds MUL16i
// results to RND_W significant bits, and hands the packed word downstream through a 2-deep valid/ready pipe.
`timescale 1ns/1ps
module fpalu_result_pack #(
    parameter int EXP_W = 6,
    parameter int MAN_W = 22,
    parameter int RND_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_opcode,
    input  logic             in_sgn,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [MAN_W-1:0] in_man_dn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_y_sgn,
    output logic [EXP_W-1:0] out_y_exp,
    output logic [MAN_W-1:0] out_y_man,
    output logic [3:0]       out_flags
);
    localparam int LZ_W = $clog2(MAN_W + 1);
    localparam int LOW_W = MAN_W - RND_W;

    function automatic logic [LZ_W-1:0] lzc(input logic [MAN_W-1:0] v);
        logic [LZ_W-1:0] n;
        n = LZ_W'(MAN_W);
        // Ascending scan: the highest set bit is the last one to write n.
        for (int i = 0; i < MAN_W; i++) begin
            if (v[i]) begin
                n = LZ_W'(MAN_W - 1 - i);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    logic             s1_valid_r;
    logic [1:0]       s1_op_r;
    logic             s1_sgn_r;
    logic [EXP_W-1:0] s1_exp_r;
    logic [MAN_W-1:0] s1_man_r;
    logic             s1_uf_r;
    logic             s1_zero_r;

    logic             out_valid_r;
    logic             out_sgn_r;
    logic [EXP_W-1:0] out_exp_r;
    logic [MAN_W-1:0] out_man_r;
    logic [3:0]       out_flags_r;

    logic             s1_moves_s;
    logic             out_load_s;
    logic [LZ_W-1:0]  lz_s;
    logic [EXP_W-1:0] n_exp_s;
    logic [MAN_W-1:0] n_man_s;
    logic             n_uf_s;
    logic             n_zero_s;

    logic [RND_W-1:0] keep_s;
    logic             guard_s;
    logic             sticky_s;
    logic             inc_s;
    logic [RND_W:0]   sum_s;
    logic [EXP_W-1:0] r_exp_s;
    logic [MAN_W-1:0] r_man_s;
    logic             r_ovf_s;
    logic             r_inexact_s;

    assign out_load_s = !out_valid_r | out_ready;
    assign s1_moves_s = s1_valid_r & out_load_s;
    assign in_ready   = !s1_valid_r | s1_moves_s;

    // Stage 1 normalize: shift out leading zeros, stopping at exponent zero on underflow.
    always_comb begin
        lz_s     = lzc(in_man_dn);
        n_exp_s  = {EXP_W{1'b0}};
        n_man_s  = {MAN_W{1'b0}};
        n_uf_s   = 1'b0;
        n_zero_s = 1'b0;
        if (in_man_dn == {MAN_W{1'b0}}) begin
            n_zero_s = 1'b1;
        end else if (in_exp > EXP_W'(lz_s)) begin
            n_exp_s = in_exp - EXP_W'(lz_s);
            n_man_s = in_man_dn << lz_s;
        end else begin
            n_man_s = in_man_dn << in_exp;
            n_uf_s  = 1'b1;
        end
    end

    // Stage 2 round: half-to-even on the kept MSBs for MUL16i, identity otherwise.
    always_comb begin
        keep_s      = s1_man_r[MAN_W-1 -: RND_W];
        guard_s     = s1_man_r[LOW_W-1];
        sticky_s    = |s1_man_r[LOW_W-2:0];
        inc_s       = guard_s & (sticky_s | keep_s[0]);
        sum_s       = {1'b0, keep_s} + {{RND_W{1'b0}}, inc_s};
        r_exp_s     = s1_exp_r;
        r_man_s     = s1_man_r;
        r_ovf_s     = 1'b0;
        r_inexact_s = 1'b0;
        if (s1_op_r == 2'b10) begin
            r_inexact_s = guard_s | sticky_s;
            if (sum_s[RND_W]) begin
                if (s1_exp_r != {EXP_W{1'b1}}) begin
                    r_exp_s = s1_exp_r + {{(EXP_W-1){1'b0}}, 1'b1};
                    r_man_s = {1'b1, {(MAN_W-1){1'b0}}};
                end else begin
                    r_exp_s = {EXP_W{1'b1}};
                    r_man_s = {{RND_W{1'b1}}, {LOW_W{1'b0}}};
                    r_ovf_s = 1'b1;
                end
            end else begin
                r_man_s = {sum_s[RND_W-1:0], {LOW_W{1'b0}}};
            end
        end else begin
            r_inexact_s = 1'b0;
        end
    end

    // Stage 1 register: loads whenever the stage is empty or its content moves on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= 2'b00;
            s1_sgn_r   <= 1'b0;
            s1_exp_r   <= {EXP_W{1'b0}};
            s1_man_r   <= {MAN_W{1'b0}};
            s1_uf_r    <= 1'b0;
            s1_zero_r  <= 1'b0;
        end else if (in_ready) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_op_r   <= in_opcode;
                s1_sgn_r  <= in_sgn;
                s1_exp_r  <= n_exp_s;
                s1_man_r  <= n_man_s;
                s1_uf_r   <= n_uf_s;
                s1_zero_r <= n_zero_s;
            end
        end
    end

    // Output register: holds its word while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_sgn_r   <= 1'b0;
            out_exp_r   <= {EXP_W{1'b0}};
            out_man_r   <= {MAN_W{1'b0}};
            out_flags_r <= 4'b0000;
        end else if (out_load_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_sgn_r   <= s1_sgn_r;
                out_exp_r   <= r_exp_s;
                out_man_r   <= r_man_s;
                out_flags_r <= {r_ovf_s, s1_uf_r, r_inexact_s, s1_zero_r};
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_y_sgn = out_sgn_r;
    assign out_y_exp = out_exp_r;
    assign out_y_man = out_man_r;
    assign out_flags = out_flags_r;

endmodule

// File: tb/tb_fpalu_result_pack.sv
// Self-checking bench for fpalu_result_pack: directed spec cases plus randomized traffic
// scored against an arithmetic reference model.
`timescale 1ns/1ps
module tb_fpalu_result_pack;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_opcode;
    logic        in_sgn;
    logic [5:0]  in_exp;
    logic [21:0] in_man_dn;
    logic        out_valid;
    logic        out_ready;
    logic        out_y_sgn;
    logic [5:0]  out_y_exp;
    logic [21:0] out_y_man;
    logic [3:0]  out_flags;

    int checks = 0;
    int failures = 0;
    logic [32:0] exp_q[$];

    fpalu_result_pack dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_sgn(in_sgn), .in_exp(in_exp), .in_man_dn(in_man_dn),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y_sgn(out_y_sgn), .out_y_exp(out_y_exp), .out_y_man(out_y_man),
        .out_flags(out_flags)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Reference: value-level normalize by doubling, then round via quotient/remainder by 2^11.
    function automatic logic [32:0] model(input logic [1:0] op, input logic sgn,
                                          input logic [5:0] ex, input logic [21:0] man);
        int m, e, q, r;
        logic ovf, uf, inx, zero;
        m = int'(man);
        e = int'(ex);
        ovf = 1'b0; uf = 1'b0; inx = 1'b0; zero = 1'b0;
        if (m == 0) begin
            zero = 1'b1;
            e = 0;
        end else begin
            while (m < 'h200000 && e > 0) begin
                m = m * 2;
                e = e - 1;
            end
            uf = (e == 0);
            if (op == 2'b10) begin
                q = m / 2048;
                r = m % 2048;
                inx = (r != 0);
                if (r > 1024 || (r == 1024 && (q % 2) == 1)) q = q + 1;
                if (q == 2048) begin
                    if (e < 63) begin
                        e = e + 1;
                        m = 'h200000;
                    end else begin
                        m = 'h3FF800;
                        ovf = 1'b1;
                    end
                end else begin
                    m = q * 2048;
                end
            end
        end
        return {sgn, 6'(e), 22'(m), ovf, uf, inx, zero};
    endfunction

    task automatic step(input logic v, input logic [1:0] op, input logic s, input logic [5:0] e,
                        input logic [21:0] m, input logic ordy,
                        output logic in_fire, output logic out_fire, output logic [32:0] obs);
        in_valid = v; in_opcode = op; in_sgn = s; in_exp = e; in_man_dn = m; out_ready = ordy;
        #1;
        in_fire  = in_valid & in_ready;
        out_fire = out_valid & out_ready;
        obs = {out_y_sgn, out_y_exp, out_y_man, out_flags};
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_opcode = 2'b00; in_sgn = 1'b0; in_exp = 6'd0; in_man_dn = 22'd0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++;
        if ({out_y_sgn, out_y_exp, out_y_man, out_flags} !== 33'd0) begin
            failures++; $display("FAIL reset_out_word got=%h want=0", {out_y_sgn, out_y_exp, out_y_man, out_flags});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        logic fi, fo;
        logic [32:0] obs;
        step(1'b1, 2'b11, 1'b0, 6'd20, 22'h008000, 1'b1, fi, fo, obs);
        step(1'b1, 2'b10, 1'b1, 6'd30, 22'h3FFC00, 1'b1, fi, fo, obs);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL midreset_inflight got=%b want=1", out_valid); end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_immediate got=%b want=0", out_valid); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready got=%b want=1", in_ready); end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b00, 1'b0, 6'd0, 22'd0, 1'b1, fi, fo, obs);
            checks++;
            if (fo !== 1'b0) begin failures++; $display("FAIL midreset_stale cycle=%0d got=%b want=0", i, fo); end
        end
    endtask

    task automatic run_directed(input string name, input logic [1:0] op, input logic s,
                                input logic [5:0] e, input logic [21:0] m, input logic [32:0] want);
        logic fi, fo;
        logic [32:0] obs;
        step(1'b1, op, s, e, m, 1'b1, fi, fo, obs);
        checks++;
        if (fi !== 1'b1) begin failures++; $display("FAIL %s_accept got=%b want=1", name, fi); end
        step(1'b0, 2'b00, 1'b0, 6'd0, 22'd0, 1'b1, fi, fo, obs);
        checks++;
        if (fo !== 1'b0) begin failures++; $display("FAIL %s_early got=%b want=0", name, fo); end
        step(1'b0, 2'b00, 1'b0, 6'd0, 22'd0, 1'b1, fi, fo, obs);
        checks++;
        if (fo !== 1'b1 || obs !== want) begin
            failures++; $display("FAIL %s valid=%b got=%h want=%h", name, fo, obs, want);
        end
    endtask

    task automatic test_add_normalize();
        run_directed("add_norm", 2'b11, 1'b0, 6'd20, 22'h008000, {1'b0, 6'd14, 22'h200000, 4'b0000});
    endtask

    task automatic test_mul_round();
        run_directed("mul_carry", 2'b10, 1'b0, 6'd10, 22'h3FFC00, {1'b0, 6'd11, 22'h200000, 4'b0010});
        run_directed("mul_tie_even", 2'b10, 1'b0, 6'd10, 22'h3FF400, {1'b0, 6'd10, 22'h3FF000, 4'b0010});
    endtask

    task automatic test_zero_underflow();
        run_directed("zero", 2'b11, 1'b1, 6'd40, 22'h000000, {1'b1, 6'd0, 22'h000000, 4'b0001});
        run_directed("underflow", 2'b11, 1'b0, 6'd3, 22'h000100, {1'b0, 6'd0, 22'h000800, 4'b0100});
    endtask

    task automatic test_overflow();
        run_directed("overflow", 2'b10, 1'b0, 6'd63, 22'h3FFFFF, {1'b0, 6'd63, 22'h3FF800, 4'b1010});
    endtask

    task automatic test_backpressure();
        logic fi, fo;
        logic [32:0] obs, want;
        logic [21:0] mans [3];
        mans[0] = 22'h012345; mans[1] = 22'h3FF400; mans[2] = 22'h000ABC;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b10, 1'b0, 6'd25, mans[i], 1'b0, fi, fo, obs);
            checks++;
            if (fi !== (i < 2)) begin failures++; $display("FAIL bp_accept idx=%0d got=%b want=%b", i, fi, (i < 2)); end
            if (fi) exp_q.push_back(model(2'b10, 1'b0, 6'd25, mans[i]));
        end
        step(1'b1, 2'b10, 1'b0, 6'd25, mans[2], 1'b1, fi, fo, obs);
        if (fi) exp_q.push_back(model(2'b10, 1'b0, 6'd25, mans[2]));
        checks++;
        if (fi !== 1'b1) begin failures++; $display("FAIL bp_third_accept got=%b want=1", fi); end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step(1'b0, 2'b00, 1'b0, 6'd0, 22'd0, 1'b1, fi, fo, obs);
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 33'd0;
            checks++;
            if (fo !== 1'b1 || obs !== want) begin
                failures++; $display("FAIL bp_drain idx=%0d valid=%b got=%h want=%h", i, fo, obs, want);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic fi, fo;
        logic [32:0] obs, want;
        logic [21:0] m;
        int got;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            m = 22'($urandom);
            step(i < 8, 2'($urandom), 1'($urandom), 6'($urandom), m, 1'b1, fi, fo, obs);
            if (fi) exp_q.push_back(model(in_opcode, in_sgn, in_exp, in_man_dn));
            if (i < 8) begin
                checks++;
                if (fi !== 1'b1) begin failures++; $display("FAIL b2b_accept idx=%0d got=%b want=1", i, fi); end
            end
            if (i >= 2) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 33'd0;
                checks++;
                if (fo !== 1'b1 || obs !== want) begin
                    failures++; $display("FAIL b2b_out idx=%0d valid=%b got=%h want=%h", i, fo, obs, want);
                end
                got++;
            end
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        logic fi, fo;
        logic [32:0] obs, want;
        logic [1:0] op;
        logic s;
        logic [5:0] e;
        logic [21:0] m;
        logic have;
        int sent, recv, cyc;
        sent = 0; recv = 0; cyc = 0; have = 1'b0;
        op = 2'b00; s = 1'b0; e = 6'd0; m = 22'd0;
        while ((sent < 200 || exp_q.size() > 0) && cyc < 3000) begin
            if (!have && sent < 200 && ($urandom_range(0, 3) != 0)) begin
                op = 2'($urandom);
                s  = 1'($urandom);
                e  = 6'($urandom);
                m  = 22'($urandom) >> $urandom_range(0, 22);
                have = 1'b1;
            end
            step(have, op, s, e, m, (sent >= 200) ? 1'b1 : 1'($urandom), fi, fo, obs);
            if (fi) begin
                exp_q.push_back(model(op, s, e, m));
                sent++;
                have = 1'b0;
            end
            if (fo) begin
                recv++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rand_extra got=%h want=none", obs);
                end else begin
                    want = exp_q.pop_front();
                    if (obs !== want) begin
                        failures++; $display("FAIL rand_data idx=%0d got=%h want=%h", recv - 1, obs, want);
                    end
                end
            end
            cyc++;
        end
        checks++;
        if (recv !== 200 || sent !== 200) begin
            failures++; $display("FAIL rand_count sent=%0d recv=%0d want=200", sent, recv);
        end
    endtask

    initial begin
        test_reset();
        test_reset_midstream();
        test_add_normalize();
        test_mul_round();
        test_zero_underflow();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
